// File: rtl/mouse_master_sm.sv
// mouse_master_sm: top-level PS/2 mouse sequencer.
// Runs the power-up handshake (reset, ACK, self-test, ID, enable, ACK).
// It then assembles 3-byte movement packets and pulses SEND_INTERRUPT
// once for each complete, error-free packet.
module mouse_master_sm #(
    parameter int unsigned INIT_WAIT_CYCLES    = 1000000,
    parameter int unsigned RESP_TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  CMD_RESET           = 8'hFF,
    parameter logic [7:0]  CMD_ENABLE          = 8'hF4
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic       INIT_DONE,
    output logic [3:0] MASTER_STATE
);

    localparam logic [3:0] S_INIT          = 4'd0;
    localparam logic [3:0] S_SEND_RST      = 4'd1;
    localparam logic [3:0] S_WAIT_RST_SENT = 4'd2;
    localparam logic [3:0] S_ACK_RST       = 4'd3;
    localparam logic [3:0] S_SELFTEST      = 4'd4;
    localparam logic [3:0] S_ID            = 4'd5;
    localparam logic [3:0] S_SEND_EN       = 4'd6;
    localparam logic [3:0] S_WAIT_EN_SENT  = 4'd7;
    localparam logic [3:0] S_ACK_EN        = 4'd8;
    localparam logic [3:0] S_PKT1          = 4'd9;
    localparam logic [3:0] S_PKT2          = 4'd10;
    localparam logic [3:0] S_PKT3          = 4'd11;
    localparam logic [3:0] S_IRQ           = 4'd12;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [31:0] r_cnt;
    logic [7:0]  r_sh_status;
    logic [7:0]  r_sh_dx;
    logic        w_rx_ok;
    logic        w_init_exp;
    logic        w_resp_exp;

    assign w_rx_ok    = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign w_init_exp = (r_cnt == INIT_WAIT_CYCLES - 32'd1);
    assign w_resp_exp = (r_cnt == RESP_TIMEOUT_CYCLES - 32'd1);

    // Next-state decode; an arriving byte always takes priority over a timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:          if (w_init_exp) w_next = S_SEND_RST;
            S_SEND_RST:      w_next = S_WAIT_RST_SENT;
            S_WAIT_RST_SENT: begin
                if (BYTE_SENT)       w_next = S_ACK_RST;
                else if (w_resp_exp) w_next = S_INIT;
            end
            S_ACK_RST: begin
                if (BYTE_READY)      w_next = (w_rx_ok && BYTE_READ == 8'hFA) ? S_SELFTEST : S_INIT;
                else if (w_resp_exp) w_next = S_INIT;
            end
            S_SELFTEST: begin
                if (BYTE_READY)      w_next = (w_rx_ok && BYTE_READ == 8'hAA) ? S_ID : S_INIT;
                else if (w_resp_exp) w_next = S_INIT;
            end
            S_ID: begin
                if (BYTE_READY)      w_next = (w_rx_ok && BYTE_READ == 8'h00) ? S_SEND_EN : S_INIT;
                else if (w_resp_exp) w_next = S_INIT;
            end
            S_SEND_EN:       w_next = S_WAIT_EN_SENT;
            S_WAIT_EN_SENT: begin
                if (BYTE_SENT)       w_next = S_ACK_EN;
                else if (w_resp_exp) w_next = S_INIT;
            end
            S_ACK_EN: begin
                if (BYTE_READY)      w_next = (w_rx_ok && BYTE_READ == 8'hFA) ? S_PKT1 : S_INIT;
                else if (w_resp_exp) w_next = S_INIT;
            end
            // Packet byte 1 must carry the always-one bit 3; anything else is
            // dropped so the stream resynchronises on a plausible header.
            S_PKT1:          if (w_rx_ok && BYTE_READ[3]) w_next = S_PKT2;
            S_PKT2: begin
                if (BYTE_READY)      w_next = w_rx_ok ? S_PKT3 : S_PKT1;
                else if (w_resp_exp) w_next = S_PKT1;
            end
            S_PKT3: begin
                if (BYTE_READY)      w_next = w_rx_ok ? S_IRQ : S_PKT1;
                else if (w_resp_exp) w_next = S_PKT1;
            end
            S_IRQ:           w_next = S_PKT1;
            default:         w_next = S_INIT;
        endcase
    end

    // State register and shared cycle counter (cleared on every state change).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_INIT;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
        end
    end

    // Registered outputs, decoded from the next state so they line up with MASTER_STATE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= 8'h00;
            READ_ENABLE    <= 1'b0;
            INIT_DONE      <= 1'b0;
            SEND_INTERRUPT <= 1'b0;
            MOUSE_STATUS   <= 8'h00;
            MOUSE_DX       <= 8'h00;
            MOUSE_DY       <= 8'h00;
        end else begin
            SEND_BYTE      <= (w_next == S_SEND_RST) || (w_next == S_SEND_EN);
            READ_ENABLE    <= (w_next == S_ACK_RST) || (w_next == S_SELFTEST) ||
                              (w_next == S_ID) || (w_next == S_ACK_EN) ||
                              (w_next == S_PKT1) || (w_next == S_PKT2) || (w_next == S_PKT3);
            INIT_DONE      <= (w_next >= S_PKT1) && (w_next <= S_IRQ);
            SEND_INTERRUPT <= (w_next == S_IRQ);
            if (w_next == S_SEND_RST)
                BYTE_TO_SEND <= CMD_RESET;
            else if (w_next == S_SEND_EN)
                BYTE_TO_SEND <= CMD_ENABLE;
            // The packet becomes visible in the IRQ cycle itself; the DY byte is
            // taken straight from the receiver since it arrives on that same edge.
            if (r_state == S_PKT3 && w_next == S_IRQ) begin
                MOUSE_STATUS <= r_sh_status;
                MOUSE_DX     <= r_sh_dx;
                MOUSE_DY     <= BYTE_READ;
            end
        end
    end

    // Shadow registers for the first two packet bytes (pure data, no reset needed).
    always_ff @(posedge CLK) begin
        if (r_state == S_PKT1 && w_next == S_PKT2)
            r_sh_status <= BYTE_READ;
        if (r_state == S_PKT2 && w_next == S_PKT3)
            r_sh_dx <= BYTE_READ;
    end

    assign MASTER_STATE = r_state;

endmodule
